// File: rtl/router_pkg.sv
// Shared router constants: default flit width, output-buffer depth, VC count,
// and the VC index width used on every VC-select port.
package router_pkg;

  localparam int FLIT_W   = 64;
  localparam int OB_DEPTH = 4;
  localparam int NUM_VC   = 2;

  // VC index width; a single VC still gets a 1-bit select so ports never collapse.
  function automatic int vc_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int VCW = vc_width(NUM_VC);

endpackage : router_pkg

// File: rtl/outbuf_vc_chan.sv
// Single virtual-channel circular FIFO: storage, read/write pointers,
// occupancy count, full/empty flags and a head-of-queue peek.
module outbuf_vc_chan #(
  parameter int WIDTH = router_pkg::FLIT_W,
  parameter int DEPTH = router_pkg::OB_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic wr_ok;
  logic rd_ok;

  // Flags come only from registered occupancy, never from this cycle's requests.
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem[rd_ptr_q];

  // Local guards keep the count consistent even if a caller ignores the flags.
  assign wr_ok = wr_en & ~full;
  assign rd_ok = rd_en & ~empty;

  // Next-state for pointers and occupancy; DEPTH is a power of two so the
  // pointer increment wraps from DEPTH-1 to 0 on its own.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy state, cleared asynchronously so the channel reads empty.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Flit storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage has no reset; empty/count gate every read, so stale contents are never visible.
    if (wr_ok) mem[wr_ptr_q] <= wr_data;
  end

endmodule : outbuf_vc_chan

// File: rtl/outbuf_vc_fifo.sv
// Router output buffer: NUM_VC independent FIFOs, enqueue gated by the
// internal phase, Mealy send strobe gated by the external phase and
// downstream ready, plus a one-cycle overflow pulse on rejected enqueues.
module outbuf_vc_fifo #(
  parameter  int WIDTH  = router_pkg::FLIT_W,
  parameter  int DEPTH  = router_pkg::OB_DEPTH,
  parameter  int NUM_VC = router_pkg::NUM_VC,
  localparam int VCW    = router_pkg::vc_width(NUM_VC)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enq,
  input  logic [VCW-1:0]    enq_vc,
  input  logic [WIDTH-1:0]  d_in,
  input  logic              phase_internal,
  input  logic              phase_external,
  input  logic [VCW-1:0]    ext_vc,
  input  logic              ro,
  output logic              so,
  output logic [WIDTH-1:0]  dout,
  output logic [NUM_VC-1:0] full,
  output logic [NUM_VC-1:0] empty,
  output logic [WIDTH-1:0]  q,
  output logic              ovf
);

  logic [NUM_VC-1:0] wr_en;
  logic [NUM_VC-1:0] rd_en;
  logic [WIDTH-1:0]  head [NUM_VC];

  logic [WIDTH-1:0]  sel_head;
  logic              sel_empty;
  logic              ovf_q, ovf_d;

  for (genvar g = 0; g < NUM_VC; g++) begin : g_chan
    outbuf_vc_chan #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_chan (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en[g]),
      .wr_data (d_in),
      .rd_en   (rd_en[g]),
      .full    (full[g]),
      .empty   (empty[g]),
      .head    (head[g])
    );
  end

  // Enqueue decode and ext_vc head select; VC indices >= NUM_VC match no
  // channel, so they enqueue nothing and present an empty head.
  always_comb begin
    wr_en     = '0;
    ovf_d     = 1'b0;
    sel_head  = '0;
    sel_empty = 1'b1;
    for (int v = 0; v < NUM_VC; v++) begin
      if (enq && phase_internal && (enq_vc == VCW'(v))) begin
        if (full[v]) ovf_d    = 1'b1;
        else         wr_en[v] = 1'b1;
      end
      if (ext_vc == VCW'(v)) begin
        sel_head  = head[v];
        sel_empty = empty[v];
      end
    end
  end

  // Send strobe, dequeue decode and the zero-masked data outputs.
  always_comb begin
    so    = phase_external & ro & ~sel_empty;
    rd_en = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      if (ext_vc == VCW'(v)) rd_en[v] = so;
    end
    q    = sel_empty ? '0 : sel_head;
    dout = so ? q : '0;
  end

  // Overflow pulse: high for the single cycle after a rejected enqueue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;

endmodule : outbuf_vc_fifo

// File: tb/tb_outbuf_vc_fifo.sv
// Directed table-driven bench for outbuf_vc_fifo (WIDTH=64, DEPTH=4, NUM_VC=2).
module tb_outbuf_vc_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        enq;
  logic [0:0]  enq_vc;
  logic [63:0] d_in;
  logic        phase_internal;
  logic        phase_external;
  logic [0:0]  ext_vc;
  logic        ro;
  logic        so;
  logic [63:0] dout;
  logic [1:0]  full;
  logic [1:0]  empty;
  logic [63:0] q;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        enq;
    logic [0:0]  vc;
    logic [63:0] d;
    logic        pi;
    logic        pe;
    logic [0:0]  ext;
    logic        ro;
    logic        so;
    logic [63:0] dout;
    logic [63:0] q;
    logic [1:0]  full;
    logic [1:0]  empty;
    logic        ovf;
  } vec_t;

  localparam logic [63:0] FLIT_A = 64'hABCDEF0123456789;

  outbuf_vc_fifo dut (
    .clk            (clk),
    .reset          (reset),
    .enq            (enq),
    .enq_vc         (enq_vc),
    .d_in           (d_in),
    .phase_internal (phase_internal),
    .phase_external (phase_external),
    .ext_vc         (ext_vc),
    .ro             (ro),
    .so             (so),
    .dout           (dout),
    .full           (full),
    .empty          (empty),
    .q              (q),
    .ovf            (ovf)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic e, input logic [0:0] vc, input logic [63:0] d,
                              input logic pi, input logic pe, input logic [0:0] ext, input logic r,
                              input logic x_so, input logic [63:0] x_dout, input logic [63:0] x_q,
                              input logic [1:0] x_full, input logic [1:0] x_empty, input logic x_ovf);
    vec_t t;
    t.enq = e; t.vc = vc; t.d = d; t.pi = pi; t.pe = pe; t.ext = ext; t.ro = r;
    t.so = x_so; t.dout = x_dout; t.q = x_q; t.full = x_full; t.empty = x_empty; t.ovf = x_ovf;
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic e, input logic [0:0] vc, input logic [63:0] d,
                       input logic pi, input logic pe, input logic [0:0] ext, input logic r);
    enq = e; enq_vc = vc; d_in = d; phase_internal = pi;
    phase_external = pe; ext_vc = ext; ro = r;
  endtask

  task automatic check_all(input string tag, input logic x_so, input logic [63:0] x_dout,
                           input logic [63:0] x_q, input logic [1:0] x_full,
                           input logic [1:0] x_empty, input logic x_ovf);
    check({tag, " so"},    {63'd0, so},    {63'd0, x_so});
    check({tag, " dout"},  dout,           x_dout);
    check({tag, " q"},     q,              x_q);
    check({tag, " full"},  {62'd0, full},  {62'd0, x_full});
    check({tag, " empty"}, {62'd0, empty}, {62'd0, x_empty});
    check({tag, " ovf"},   {63'd0, ovf},   {63'd0, x_ovf});
  endtask

  // Apply each row, check the pre-edge outputs, then take one clock edge.
  task automatic run_table(input string seg, input vec_t tbl[$]);
    foreach (tbl[i]) begin
      drive(tbl[i].enq, tbl[i].vc, tbl[i].d, tbl[i].pi, tbl[i].pe, tbl[i].ext, tbl[i].ro);
      #1;
      check_all($sformatf("%s[%0d]", seg, i), tbl[i].so, tbl[i].dout, tbl[i].q,
                tbl[i].full, tbl[i].empty, tbl[i].ovf);
      @(posedge clk); #1;
    end
  endtask

  vec_t seg_a[$];
  vec_t seg_b[$];

  initial begin
    // Segment A: first enqueue peek, ignored enqueue outside the internal phase.
    //                enq vc  d          pi pe ext ro   so dout q       full   empty  ovf
    seg_a.push_back(mk(1, 0, FLIT_A,     1, 0, 0, 0,   0, 0,   0,      2'b00, 2'b11, 0));
    seg_a.push_back(mk(0, 0, 0,          0, 0, 0, 0,   0, 0,   FLIT_A, 2'b00, 2'b10, 0));
    seg_a.push_back(mk(1, 1, 64'hDEAD,   0, 0, 1, 0,   0, 0,   0,      2'b00, 2'b10, 0));
    seg_a.push_back(mk(0, 0, 0,          0, 0, 1, 0,   0, 0,   0,      2'b00, 2'b10, 0));

    // Segment B: vc1 fill/overflow/drain, vc0 wrap with simultaneous enq+deq, VC isolation.
    seg_b.push_back(mk(1, 1, 64'd1,      1, 0, 1, 0,   0, 0,      0,      2'b00, 2'b11, 0));
    seg_b.push_back(mk(1, 1, 64'd2,      1, 0, 1, 0,   0, 0,      64'd1,  2'b00, 2'b01, 0));
    seg_b.push_back(mk(1, 1, 64'd3,      1, 0, 1, 0,   0, 0,      64'd1,  2'b00, 2'b01, 0));
    seg_b.push_back(mk(1, 1, 64'd4,      1, 0, 1, 0,   0, 0,      64'd1,  2'b00, 2'b01, 0));
    seg_b.push_back(mk(1, 1, 64'd5,      1, 0, 1, 0,   0, 0,      64'd1,  2'b10, 2'b01, 0));
    seg_b.push_back(mk(0, 0, 0,          0, 0, 1, 0,   0, 0,      64'd1,  2'b10, 2'b01, 1));
    seg_b.push_back(mk(1, 1, 64'd5,      1, 1, 1, 1,   1, 64'd1,  64'd1,  2'b10, 2'b01, 0));
    seg_b.push_back(mk(0, 0, 0,          0, 1, 1, 1,   1, 64'd2,  64'd2,  2'b00, 2'b01, 1));
    seg_b.push_back(mk(0, 0, 0,          0, 1, 1, 1,   1, 64'd3,  64'd3,  2'b00, 2'b01, 0));
    seg_b.push_back(mk(0, 0, 0,          0, 1, 1, 1,   1, 64'd4,  64'd4,  2'b00, 2'b01, 0));
    seg_b.push_back(mk(0, 0, 0,          0, 1, 1, 1,   0, 0,      0,      2'b00, 2'b11, 0));
    seg_b.push_back(mk(1, 0, 64'd7,      1, 0, 0, 0,   0, 0,      0,      2'b00, 2'b11, 0));
    seg_b.push_back(mk(1, 0, 64'd8,      1, 0, 0, 0,   0, 0,      64'd7,  2'b00, 2'b10, 0));
    seg_b.push_back(mk(1, 0, 64'd9,      1, 0, 0, 0,   0, 0,      64'd7,  2'b00, 2'b10, 0));
    for (int k = 0; k < 6; k++) begin
      seg_b.push_back(mk(1, 0, 64'(10 + k), 1, 1, 0, 1,
                         1, 64'(7 + k), 64'(7 + k), 2'b00, 2'b10, 0));
    end
    for (int k = 0; k < 3; k++) begin
      seg_b.push_back(mk(0, 0, 0, 0, 1, 0, 1,
                         1, 64'(13 + k), 64'(13 + k), 2'b00, 2'b10, 0));
    end
    seg_b.push_back(mk(0, 0, 0,          0, 1, 0, 1,   0, 0,      0,       2'b00, 2'b11, 0));
    seg_b.push_back(mk(1, 0, 64'h100,    1, 0, 0, 0,   0, 0,      0,       2'b00, 2'b11, 0));
    seg_b.push_back(mk(1, 1, 64'h200,    1, 0, 0, 0,   0, 0,      64'h100, 2'b00, 2'b10, 0));
    seg_b.push_back(mk(0, 0, 0,          0, 1, 1, 1,   1, 64'h200, 64'h200, 2'b00, 2'b00, 0));
    seg_b.push_back(mk(0, 0, 0,          0, 1, 1, 1,   0, 0,      0,       2'b00, 2'b10, 0));
    seg_b.push_back(mk(0, 0, 0,          0, 0, 0, 0,   0, 0,      64'h100, 2'b00, 2'b10, 0));

    // Reset with a live downstream request so so=0 is a real check.
    drive(0, 0, 0, 0, 1, 0, 1);
    reset = 1'b1;
    #1;
    check_all("reset", 0, 0, 0, 2'b00, 2'b11, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    run_table("seg_a", seg_a);

    // Mealy send: ro rises mid-cycle and so/dout follow without an edge.
    drive(0, 0, 0, 0, 1, 0, 0);
    #1;
    check("mealy so ro=0",   {63'd0, so}, 64'd0);
    check("mealy dout ro=0", dout,        64'd0);
    ro = 1'b1;
    #1;
    check("mealy so ro=1",   {63'd0, so}, 64'd1);
    check("mealy dout ro=1", dout,        FLIT_A);
    @(posedge clk); #1;
    check("mealy empty after deq", {62'd0, empty}, 64'd3);
    check("mealy so after deq",    {63'd0, so},    64'd0);

    run_table("seg_b", seg_b);

    // vc0 holds 0x100; fill vc1 and overflow it, then reset mid-drain.
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, 64'(16'h300 + k), 1, 0, 0, 0);
      @(posedge clk); #1;
    end
    drive(1, 1, 64'h3FF, 1, 0, 0, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 1, 0, 1);
    #1;
    check_all("pre-reset", 1, 64'h100, 64'h100, 2'b10, 2'b00, 1);
    reset = 1'b1;
    #1;
    check_all("mid reset", 0, 0, 0, 2'b00, 2'b11, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // First post-reset enqueue behaves as from empty.
    drive(1, 0, 64'h55, 1, 0, 0, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 1, 0);
    #1;
    check_all("post-reset vc1", 0, 0, 0, 2'b00, 2'b10, 0);
    ext_vc = 1'b0;
    #1;
    check("post-reset q vc0", q, 64'h55);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule : tb_outbuf_vc_fifo

// File: doc/outbuf_vc_fifo.md
OUTBUF_VC_FIFO -- requirements
Module: outbuf_vc_fifo

Interface
REQ-001 Parameter WIDTH, default 64, flit width in bits.
REQ-002 Parameter DEPTH, default 4, entries per VC; power of two, minimum 2.
REQ-003 Parameter NUM_VC, default 2, number of virtual channels; VCW = max(1, clog2(NUM_VC)).
REQ-004 Port clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port reset  input  1  reset, asynchronous and active-high.
REQ-006 Port enq  input  1  enqueue request from router core.
REQ-007 Port enq_vc  input  VCW  target VC of enqueue.
REQ-008 Port d_in  input  WIDTH  flit to enqueue.
REQ-009 Port phase_internal  input  1  enqueue window qualifier.
REQ-010 Port phase_external  input  1  send window qualifier.
REQ-011 Port ext_vc  input  VCW  VC eligible to send this cycle.
REQ-012 Port ro  input  1  downstream ready.
REQ-013 Port so  output  1  send strobe (combinational).
REQ-014 Port dout  output  WIDTH  outgoing flit, zero when so=0.
REQ-015 Port full  output  NUM_VC  per-VC full flags.
REQ-016 Port empty  output  NUM_VC  per-VC empty flags.
REQ-017 Port q  output  WIDTH  head entry of ext_vc regardless of so (debug/peek); zero if that VC empty.
REQ-018 Port ovf  output  1  one-cycle pulse: enqueue rejected.

Function
REQ-019 Each VC SHALL be an independent circular FIFO of DEPTH entries with rd/wr pointers and occupancy count of width clog2(DEPTH+1).
REQ-020 Enqueue SHALL occur at posedge iff enq & phase_internal & ~full[enq_vc]; d_in written at wr pointer, pointer and count advance.
REQ-021 enq with phase_internal=0 SHALL be ignored silently (no write, no ovf).
REQ-022 enq & phase_internal & full[enq_vc] (pre-edge value) SHALL not write and SHALL assert ovf for exactly the following cycle; rejection holds even if the same VC dequeues that edge.
REQ-023 so SHALL equal phase_external & ~empty[ext_vc] & ro, combinationally (Mealy).
REQ-024 dout SHALL equal head of ext_vc when so=1, else all zeros.
REQ-025 Dequeue SHALL occur at posedge iff so=1; rd pointer advances, count decrements; no data latency beyond that edge.
REQ-026 Simultaneous enqueue and dequeue on the same non-full VC SHALL both take effect; count unchanged.
REQ-027 Enqueue and dequeue on different VCs SHALL be fully independent.
REQ-028 Pointers SHALL wrap from DEPTH-1 to 0.
REQ-029 full[v] = (count==DEPTH); empty[v] = (count==0); both registered-state derived, no input dependence.
REQ-030 enq_vc or ext_vc >= NUM_VC SHALL be treated as no-op (no enqueue / so=0).
REQ-031 FIFO order per VC SHALL be strictly preserved.

Reset
REQ-032 On reset assertion, asynchronously: all counts and pointers 0, empty all ones, full all zeros, ovf 0; hence so=0, dout=0, q=0.
REQ-033 Storage array contents SHALL NOT be reset.
REQ-034 Reset mid-operation SHALL discard all queued flits; first post-reset edge behaves as from empty.

Structure
REQ-035 Shared package router_pkg SHALL hold defaults FLIT_W=64, OB_DEPTH=4, NUM_VC=2 and the VCW computation.
REQ-036 One sub-module outbuf_vc_chan (single-VC FIFO: storage, pointers, count, full/empty, head) SHALL be instantiated NUM_VC times via generate; top holds enq/deq decode, so/dout mux, ovf register.

Verification
REQ-037 Reset, enq=1 vc0 d_in=64'hABCDEF0123456789 phase_internal=1, one edge -> empty=2'b10, full=0, ext_vc=0 peek q=ABCDEF0123456789.
REQ-038 vc0 holds 1 flit, phase_external=1 ro=0 -> so=0 dout=0; raise ro mid-cycle -> so=1 dout=flit immediately; next edge -> empty[0]=1, so=0.
REQ-039 Enqueue 1,2,3,4 to vc1 -> full[1]=1; 5th enqueue -> ovf pulse one cycle, vc1 unchanged; drain with ro=1 -> dout 1,2,3,4 in order, then so=0.
REQ-040 Fill vc0 to 3, then 6 cycles simultaneous enq+deq vc0 (values 10..15) -> count stays 3, pointers wrap, dout order preserved.
REQ-041 vc0 and vc1 each hold one flit, ext_vc=1 ro=1 -> only vc1 drains; vc0 untouched, empty=2'b10.
REQ-042 Assert reset with both VCs non-empty mid-drain -> so, dout, full, ovf drop to 0 immediately, empty=2'b11.
